// File: rtl/i2s_rx_pkg.sv
// Shared types and constants for the I2S target receiver.
`timescale 1ns/1ps

package i2s_rx_pkg;

    // Receiver states: idle while disabled, hunting for a word boundary, then
    // deserialising whole words.
    typedef enum logic [1:0] {
        DISABLED,
        WAIT_WS,
        RECEIVE
    } rx_state_e;

    // Word-select level for each channel (Philips format).
    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_sync.sv
// Multi-flop synchroniser for a bit clock and its companion lines.
// Bit 0 of async_i is the bit clock: only its rising edge is exported.
// The remaining bits are exported as synchronised levels that are aligned
// cycle-for-cycle with that edge pulse.
`timescale 1ns/1ps

module i2s_rx_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-2:0] lines_o,
    output logic             rise_o
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic             clk_prev_q;

    // Shift the asynchronous lines through the flop chain and remember the
    // previous synchronised clock level for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: this array is a short chain of real flops, not a RAM, so
            // every element is reset to give a known start-up level.
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
            clk_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old
            // value of its neighbour, which is what makes this a chain.
            stage_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            clk_prev_q <= stage_q[STAGES-1][0];
        end
    end

    assign lines_o = stage_q[STAGES-1][WIDTH-1:1];
    assign rise_o  = stage_q[STAGES-1][0] & ~clk_prev_q;

endmodule

// File: rtl/i2s_target_rx.sv
// I2S (Philips format) target receiver. The SoC drives sck/ws/sd and this
// block oversamples them, deserialises each channel slot into an
// MSB-aligned word and offers it on a valid/ready stream. Words completed
// while the consumer is stalled are dropped and flagged via overflow_o.
`timescale 1ns/1ps

module i2s_target_rx
    import i2s_rx_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  i2s_sck_i,
    input  logic                  i2s_ws_i,
    input  logic                  i2s_sd_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  channel_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overflow_o,
    input  logic                  clr_overflow_i
);

    localparam int             CW      = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DATA_WIDTH);

    logic [1:0]            lines_s;
    logic                  ws_s;
    logic                  sd_s;
    logic                  sck_rise;

    rx_state_e             state_q;
    logic                  ws_d_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;

    logic                  done_q;
    logic                  done_ch_q;
    logic [DATA_WIDTH-1:0] done_data_q;

    logic                  ws_edge;
    logic                  room;
    logic [CW-1:0]         cnt_next;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [DATA_WIDTH-1:0] word_aligned;

    // sck, ws and sd share one synchroniser so ws/sd are seen in the same
    // cycle as the sck edge that samples them.
    i2s_rx_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i ({i2s_sd_i, i2s_ws_i, i2s_sck_i}),
        .lines_o (lines_s),
        .rise_o  (sck_rise)
    );

    assign ws_s = lines_s[0];
    assign sd_s = lines_s[1];

    // Next shift/count values with the current sd bit taken in, and the word
    // left-justified as it would be if this edge closed the slot.
    always_comb begin
        // NOTE: every signal here is assigned on every path, so no latch is
        // inferred even though some results go unused in a given state.
        ws_edge      = (ws_s != ws_d_q);
        room         = (cnt_q < CNT_MAX);
        shift_next   = room ? {shift_q[DATA_WIDTH-2:0], sd_s} : shift_q;
        cnt_next     = room ? cnt_q + CW'(1) : cnt_q;
        word_aligned = shift_next << (CNT_MAX - cnt_next);
    end

    // Receive state machine: boundary hunting, bit deserialisation and the
    // registered word-complete pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= DISABLED;
            ws_d_q      <= 1'b0;
            cnt_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            done_ch_q   <= CH_LEFT;
            done_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (sck_rise) begin
                ws_d_q <= ws_s;
            end
            if (!en_i) begin
                state_q <= DISABLED;
                cnt_q   <= '0;
                shift_q <= '0;
            end else begin
                unique case (state_q)
                    DISABLED: state_q <= WAIT_WS;
                    WAIT_WS: begin
                        // The first word seen is partial; start clean at the
                        // next boundary.
                        if (sck_rise && ws_edge) begin
                            cnt_q   <= '0;
                            shift_q <= '0;
                            state_q <= RECEIVE;
                        end
                    end
                    RECEIVE: begin
                        if (sck_rise) begin
                            if (ws_edge) begin
                                // This edge carries the LSB of the ws_d_q slot.
                                done_q      <= 1'b1;
                                done_data_q <= word_aligned;
                                done_ch_q   <= ws_d_q ? CH_RIGHT : CH_LEFT;
                                cnt_q       <= '0;
                                shift_q     <= '0;
                            end else begin
                                cnt_q   <= cnt_next;
                                shift_q <= shift_next;
                            end
                        end
                    end
                    default: state_q <= DISABLED;
                endcase
            end
        end
    end

    // Output stream register with sticky overflow on a stalled consumer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o    <= 1'b0;
            data_o     <= '0;
            channel_o  <= CH_LEFT;
            overflow_o <= 1'b0;
        end else begin
            if (done_q && (!valid_o || ready_i)) begin
                valid_o   <= 1'b1;
                data_o    <= done_data_q;
                channel_o <= done_ch_q;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            // A new drop takes priority over a clear in the same cycle.
            if (done_q && valid_o && !ready_i) begin
                overflow_o <= 1'b1;
            end else if (clr_overflow_i) begin
                overflow_o <= 1'b0;
            end
        end
    end

endmodule
